// File: rtl/io_seq_pkg.sv
// Shared types for the io sequencer: FSM states, table entry layout, loop counter width.
// Entry fields are sized for the widest legal configuration; unused upper bits are held at zero.
package io_seq_pkg;

  localparam int VAL_MAX_W  = 32;
  localparam int HOLD_MAX_W = 32;
  localparam int LOOP_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [VAL_MAX_W-1:0]  value;
    logic [HOLD_MAX_W-1:0] hold;
  } entry_t;

endpackage

// File: rtl/io_seq_table.sv
// DEPTH-entry sequence table: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a programmed table survives a controller reset.
module io_seq_table
  import io_seq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_dat,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_dat
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Combinational read returns pre-write contents on a same-cycle write.
  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/io_seq_ctrl.sv
// Table-driven io sequencer: plays (value, hold) entries onto io_o with start/abort and a done pulse.
// Wrap-around playback and loop_cnt exist only when IO_SEQ_CTRL_LOOP_EN is defined.
module io_seq_ctrl
  import io_seq_pkg::*;
#(
  parameter  int          WIDTH    = 1,
  parameter  int          DEPTH    = 16,
  parameter  int          HOLD_W   = 16,
  parameter  logic [31:0] IDLE_VAL = 32'd0,
  localparam int          AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_wr,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [WIDTH-1:0]      cfg_value,
  input  logic [HOLD_W-1:0]     cfg_hold,
  input  logic [AW-1:0]         cfg_last,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loop_en,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      io_o,
  output logic [AW-1:0]         ptr,
  output logic [LOOP_CNT_W-1:0] loop_cnt
);

  localparam logic [WIDTH-1:0] IDLE_IO = IDLE_VAL[WIDTH-1:0];

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [AW-1:0]       last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]    io_q, io_d;
  logic                done_q, done_d;

  entry_t              wr_dat, rd_dat;
  logic [AW-1:0]       rd_addr, ptr_nxt;
  logic [WIDTH-1:0]    rd_val;
  logic [HOLD_W-1:0]   rd_hold;
  logic                unused_rd;

  always_comb begin
    wr_dat                    = '0;
    wr_dat.value[WIDTH-1:0]   = cfg_value;
    wr_dat.hold[HOLD_W-1:0]   = cfg_hold;
  end

  // The next entry is always pre-addressed so a step loads value and hold in one edge.
  assign ptr_nxt = (ptr_q == last_q) ? '0 : ptr_q + AW'(1);
  assign rd_addr = (state_q == IDLE) ? '0 : ptr_nxt;

  io_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .wr_en   (cfg_wr & ~busy),
    .wr_addr (cfg_addr),
    .wr_dat  (wr_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  assign rd_val    = rd_dat.value[WIDTH-1:0];
  assign rd_hold   = rd_dat.hold[HOLD_W-1:0];
  assign unused_rd = ^rd_dat;

`ifdef IO_SEQ_CTRL_LOOP_EN
  logic [LOOP_CNT_W-1:0] loop_cnt_q, loop_cnt_d;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    io_d       = io_q;
    done_d     = 1'b0;
`ifdef IO_SEQ_CTRL_LOOP_EN
    loop_cnt_d = loop_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = RUN;
          last_d     = cfg_last;
          ptr_d      = '0;
          io_d       = rd_val;
          hold_cnt_d = rd_hold;
`ifdef IO_SEQ_CTRL_LOOP_EN
          loop_cnt_d = '0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          io_d    = IDLE_IO;
          ptr_d   = '0;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end else if (ptr_q != last_q) begin
          ptr_d      = ptr_nxt;
          io_d       = rd_val;
          hold_cnt_d = rd_hold;
`ifdef IO_SEQ_CTRL_LOOP_EN
        end else if (loop_en) begin
          ptr_d      = '0;
          io_d       = rd_val;
          hold_cnt_d = rd_hold;
          if (loop_cnt_q != '1) begin
            loop_cnt_d = loop_cnt_q + LOOP_CNT_W'(1);
          end
`endif
        end else begin
          state_d = IDLE;
          io_d    = IDLE_IO;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        io_d    = IDLE_IO;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      last_q     <= '0;
      hold_cnt_q <= '0;
      io_q       <= IDLE_IO;
      done_q     <= 1'b0;
`ifdef IO_SEQ_CTRL_LOOP_EN
      loop_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      io_q       <= io_d;
      done_q     <= done_d;
`ifdef IO_SEQ_CTRL_LOOP_EN
      loop_cnt_q <= loop_cnt_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign io_o = io_q;
  assign ptr  = ptr_q;
`ifdef IO_SEQ_CTRL_LOOP_EN
  assign loop_cnt = loop_cnt_q;
`else
  assign loop_cnt = '0;
`endif

endmodule

// File: tb/tb_io_seq_ctrl.sv
// Directed + randomized bench for io_seq_ctrl; expected io streams are expanded from a table model.
module tb_io_seq_ctrl;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 16;
  localparam int HOLD_W = 16;
  localparam int AW     = 4;
`ifdef IO_SEQ_CTRL_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              cfg_wr;
  logic [AW-1:0]     cfg_addr;
  logic [WIDTH-1:0]  cfg_value;
  logic [HOLD_W-1:0] cfg_hold;
  logic [AW-1:0]     cfg_last;
  logic              start;
  logic              abort;
  logic              loop_en;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  io_o;
  logic [AW-1:0]     ptr;
  logic [15:0]       loop_cnt;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0]  m_val  [DEPTH];
  logic [HOLD_W-1:0] m_hold [DEPTH];

  io_seq_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .IDLE_VAL(32'd0)
  ) dut (
    .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_value(cfg_value), .cfg_hold(cfg_hold), .cfg_last(cfg_last),
    .start(start), .abort(abort), .loop_en(loop_en), .busy(busy),
    .done(done), .io_o(io_o), .ptr(ptr), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done, input int exp_loop);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".io"},   32'(io_o), 32'd0);
    chk({tag, ".ptr"},  32'(ptr),  32'd0);
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
    chk({tag, ".loop"}, 32'(loop_cnt), 32'(exp_loop));
  endtask

  task automatic wr(input int a, input int v, input int h);
    cfg_wr    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_value = WIDTH'(v);
    cfg_hold  = HOLD_W'(h);
    step();
    cfg_wr    = 1'b0;
    m_val[a]  = WIDTH'(v);
    m_hold[a] = HOLD_W'(h);
  endtask

  // Expected stream: each entry k of each pass repeated hold[k]+1 times back to back.
  task automatic play(input string tag, input int last, input int passes,
                      input int abort_at, input bit noise, input bit wr0);
    int exp_v[$];
    int exp_p[$];
    int exp_l[$];
    logic [WIDTH-1:0]  nv;
    logic [HOLD_W-1:0] nh;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k <= last; k++)
        for (int r = 0; r <= int'(m_hold[k]); r++) begin
          exp_v.push_back(int'(m_val[k]));
          exp_p.push_back(k);
          exp_l.push_back(LOOP_BUILD ? p : 0);
        end
    nv       = WIDTH'($urandom);
    nh       = HOLD_W'($urandom_range(0, 2));
    cfg_last = AW'(last);
    start    = 1'b1;
    loop_en  = LOOP_BUILD ? (passes > 1) : 1'b1;
    if (wr0) begin
      cfg_wr = 1'b1; cfg_addr = '0; cfg_value = nv; cfg_hold = nh;
    end
    step();
    start  = 1'b0;
    cfg_wr = 1'b0;
    if (wr0) begin
      m_val[0]  = nv;
      m_hold[0] = nh;
    end
    for (int c = 0; c < exp_v.size(); c++) begin
      chk({tag, ".io"},   32'(io_o), 32'(exp_v[c]));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".ptr"},  32'(ptr),  32'(exp_p[c]));
      chk({tag, ".done"}, 32'(done), 32'd0);
      chk({tag, ".loop"}, 32'(loop_cnt), 32'(exp_l[c]));
      loop_en = LOOP_BUILD ? (exp_l[c] < passes - 1) : 1'b1;
      if (noise) begin
        start     = 1'($urandom);
        cfg_wr    = 1'($urandom);
        cfg_addr  = AW'($urandom);
        cfg_value = WIDTH'($urandom);
        cfg_hold  = HOLD_W'($urandom);
      end
      if (c == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0; start = 1'b0; cfg_wr = 1'b0;
        chk_idle({tag, ".abort"}, 1'b0, exp_l[c]);
        return;
      end
      step();
      start  = 1'b0;
      cfg_wr = 1'b0;
    end
    chk_idle({tag, ".end"}, 1'b1, LOOP_BUILD ? passes - 1 : 0);
  endtask

  initial begin
    resetn = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_value = '0; cfg_hold = '0;
    cfg_last = '0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    step(); step();
    resetn = 1'b1;
    chk_idle("reset", 1'b0, 0);

    wr(0, 4'h3, 0);
    wr(1, 4'hA, 2);
    wr(2, 4'h5, 1);
    play("basic", 2, 1, -1, 0, 0);
    // Called on the done cycle: start must be accepted there.
    play("abort3", 2, 1, 2, 0, 0);
    step();
    chk("abort.nodone", 32'(done), 32'd0);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort", 1'b0, 0);

    play("noise", 2, 1, -1, 1, 0);
    play("after_noise", 2, 1, -1, 0, 0);
    chk("protect.e1", 32'(m_val[1]), 32'hA);

    play("wr0_same", 2, 1, -1, 0, 1);
    play("wr0_next", 2, 1, -1, 0, 0);

    for (int i = 0; i < DEPTH; i++)
      wr(i, int'($urandom), int'($urandom_range(0, 3)));
    for (int i = 0; i < 4; i++)
      play("rand", int'($urandom_range(0, DEPTH - 1)), 1, -1, 1, 0);
    play("rand_abort", DEPTH - 1, 1, int'($urandom_range(0, 20)), 0, 0);
    play("last0", 0, 1, -1, 0, 0);

    wr(0, 4'h6, 0);
    wr(1, 4'h9, 0);
    play("loop", 1, LOOP_BUILD ? 4 : 1, -1, 0, 0);
    play("loop_abort", 1, LOOP_BUILD ? 3 : 1, 3, 0, 0);

    cfg_last = AW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk_idle("midreset", 1'b0, 0);
    play("replay", 2, 1, -1, 0, 0);

    wr(0, 4'hC, 16'hFFFF);
    play("hold_max", 0, 1, -1, 0, 0);
    step();
    chk("hold_max.pulse", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
